// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// controls and a single shared memory port, counts retired instructions and
// traps on illegal opcodes or memory-handshake timeouts.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             brtaken,
    output logic             alusrcimm,
    output logic             writesreg,
    output logic             jump,
    output logic [3:0]       alucontrol,
    output logic [31:0]      simm,
    output logic [31:0]      uimm,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Wait counter holds 0..TIMEOUT_CYC-1; the last value is the final allowed wait cycle.
    localparam int                TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    // ---------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE onwards)
    // ---------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui, is_legal;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign alt       = instr[30];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_lui;

    logic [3:0]  alu_sel;
    logic [31:0] imm_sel;

    // ALU operation from opcode/funct3/funct7[5]; immediate ALU ops never yield SUB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_sel = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_sel = (is_r && alt) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
        end else if (is_branch) begin
            alu_sel = ALU_SUB;
        end
    end

    // Sign-extended immediate in the I/S/B/J layout selected by the opcode.
    always_comb begin
        imm_sel = '0;
        if (is_i || is_load) begin
            imm_sel = {{20{instr[31]}}, instr[31:20]};
        end else if (is_store) begin
            imm_sel = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end else if (is_branch) begin
            imm_sel = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end else if (is_jal) begin
            imm_sel = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer state and registered controls
    // ---------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              alusrcimm_q, alusrcimm_d;
    logic              writesreg_q, writesreg_d;
    logic              jump_q, jump_d;
    logic              pcwrite_q, pcwrite_d;
    logic              br_q, br_d;
    logic              trap_q, trap_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              wait_expired;

    assign wait_expired = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);

    // Next state plus the control values that belong to that next state.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        memread_d   = 1'b0;
        memwrite_d  = 1'b0;
        memtoreg_d  = 1'b0;
        alusrcimm_d = 1'b0;
        writesreg_d = 1'b0;
        jump_d      = 1'b0;
        pcwrite_d   = 1'b0;
        br_d        = 1'b0;
        trap_d      = trap_q;

        case (state_q)
            S_IDLE: begin
                state_d   = S_FETCH;
                memread_d = 1'b1;
                tmo_d     = '0;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end else begin
                    memread_d = 1'b1;
                    tmo_d     = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                state_d     = S_EXEC;
                alusrcimm_d = is_i | is_load | is_store;
                pcwrite_d   = is_branch;
                br_d        = is_branch;
                jump_d      = is_jal;
            end
            S_EXEC: begin
                if (is_r || is_i || is_lui || is_jal) begin
                    state_d     = S_WB;
                    writesreg_d = 1'b1;
                    pcwrite_d   = 1'b1;
                    jump_d      = is_jal;
                end else if (is_load || is_store) begin
                    state_d    = S_MEM;
                    memread_d  = is_load;
                    memwrite_d = is_store;
                    tmo_d      = '0;
                end else if (is_branch) begin
                    state_d   = S_FETCH;
                    memread_d = 1'b1;
                    tmo_d     = '0;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_store) begin
                        state_d   = S_FETCH;
                        memread_d = 1'b1;
                        tmo_d     = '0;
                    end else begin
                        state_d     = S_WB;
                        writesreg_d = 1'b1;
                        pcwrite_d   = 1'b1;
                        memtoreg_d  = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end else begin
                    memread_d  = memread_q;
                    memwrite_d = memwrite_q;
                    tmo_d      = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                memread_d = 1'b1;
                tmo_d     = '0;
            end
            default: begin
                state_d = S_TRAP;
                trap_d  = 1'b1;
            end
        endcase
    end

    // Retirement counter advances on every PC write and wraps naturally.
    assign instret_d = instret_q + CNT_W'(pcwrite);

    // Single register bank for state, controls and counters; reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            alusrcimm_q <= 1'b0;
            writesreg_q <= 1'b0;
            jump_q      <= 1'b0;
            pcwrite_q   <= 1'b0;
            br_q        <= 1'b0;
            trap_q      <= 1'b0;
            instret_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            memtoreg_q  <= memtoreg_d;
            alusrcimm_q <= alusrcimm_d;
            writesreg_q <= writesreg_d;
            jump_q      <= jump_d;
            pcwrite_q   <= pcwrite_d;
            br_q        <= br_d;
            trap_q      <= trap_d;
            instret_q   <= instret_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    logic dec_vld;

    assign dec_vld = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)    || (state_q == S_WB);

    // Handshake-dependent enables must follow mem_ready/zero within the same cycle,
    // so they are gated combinationally from registered qualifiers.
    assign irwrite    = (state_q == S_FETCH) & mem_ready;
    assign pcwrite    = pcwrite_q | ((state_q == S_MEM) & memwrite_q & mem_ready);
    assign brtaken    = br_q & (zero ^ instr[12]);

    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign memtoreg   = memtoreg_q;
    assign alusrcimm  = alusrcimm_q;
    assign writesreg  = writesreg_q;
    assign jump       = jump_q;
    assign trap       = trap_q;
    assign instret    = instret_q;

    assign alucontrol = dec_vld ? alu_sel : '0;
    assign simm       = dec_vld ? imm_sel : '0;
    assign uimm       = dec_vld ? {instr[31:12], 12'b0} : '0;

endmodule
